// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core's data-memory port.
// Word-addressed RAM plus an optional 16-byte register window.
// The window holds CYCLE, STORES, TOHOST and ERRADDR.
// Loads are combinational. Stores, counters and flags update at posedge i_clk.
// Optional feature: define DMEM_MMIO_EN to build the register window.
// Without it the window decodes as unmapped, o_tohost and o_halt read 0,
// and the error capture stays internal.

module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_DM_addr,
    input  logic [31:0] i_DM_wd,
    input  logic        i_DM_wen,
    input  logic        i_DM_ren,
    output logic [31:0] o_DM_rd,
    output logic [31:0] o_tohost,
    output logic        o_halt,
    output logic        o_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic          misaligned;
    logic          in_ram;
    logic          in_mmio;
    logic          access;
    logic          acc_err;
    logic          legal;
    logic          ram_wr;
    logic          errreg_wr;
    logic          halt_q;
    logic          err_q;
    logic [31:0]   erraddr_q;

    assign widx       = i_DM_addr[AW+1:2];
    assign misaligned = (i_DM_addr[1:0] != 2'b00);
    assign in_ram     = ({1'b0, i_DM_addr} < RAM_BYTES);
    assign access     = i_DM_wen | i_DM_ren;
    assign acc_err    = access & (misaligned | ~(in_ram | in_mmio));
    assign legal      = ~misaligned & (in_ram | in_mmio);
    assign ram_wr     = i_DM_wen & legal & in_ram & ~halt_q;
    assign o_err      = err_q;

`ifdef DMEM_MMIO_EN
    logic [31:0] cycle_q;
    logic [31:0] stores_q;
    logic [31:0] tohost_q;
    logic [31:0] mmio_rd;
    logic        tohost_wr;

    // Window is 16-byte aligned, so an upper-bit match covers base..base+15.
    assign in_mmio   = (i_DM_addr[31:4] == MMIO_BASE[31:4]);
    assign tohost_wr = i_DM_wen & legal & in_mmio & (i_DM_addr[3:2] == 2'd2) & ~halt_q;
    assign errreg_wr = i_DM_wen & legal & in_mmio & (i_DM_addr[3:2] == 2'd3);
    assign o_tohost  = tohost_q;
    assign o_halt    = halt_q;

    // Free-running cycle counter; it freezes once the core has halted.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cycle_q <= '0;
        end else if (!halt_q) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Count committed RAM stores, saturating at all-ones.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stores_q <= '0;
        end else if (ram_wr && (stores_q != 32'hFFFF_FFFF)) begin
            stores_q <= stores_q + 32'd1;
        end
    end

    // TOHOST latch; writing a value with bit0 set requests a sticky halt.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tohost_q <= '0;
            halt_q   <= 1'b0;
        end else if (tohost_wr) begin
            tohost_q <= i_DM_wd;
            if (i_DM_wd[0]) begin
                halt_q <= 1'b1;
            end
        end
    end

    // Register window read mux.
    always_comb begin
        mmio_rd = '0;
        case (i_DM_addr[3:2])
            2'd0:    mmio_rd = cycle_q;
            2'd1:    mmio_rd = stores_q;
            2'd2:    mmio_rd = tohost_q;
            default: mmio_rd = erraddr_q;
        endcase
    end
`else
    logic unused_cfg;

    assign in_mmio    = 1'b0;
    assign errreg_wr  = 1'b0;
    assign halt_q     = 1'b0;
    assign o_tohost   = '0;
    assign o_halt     = 1'b0;
    assign unused_cfg = ^{erraddr_q, MMIO_BASE};
`endif

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (ram_wr) begin
            mem[widx] <= i_DM_wd;
        end
    end

    // Error flag and first-error address capture.
    // A new error takes priority over a clearing store to ERRADDR.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else if (acc_err) begin
            err_q <= 1'b1;
            if (!err_q) begin
                erraddr_q <= i_DM_addr;
            end
        end else if (errreg_wr) begin
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end
    end

    // Combinational load data; illegal or absent loads return 0.
    always_comb begin
        o_DM_rd = '0;
        if (i_DM_ren && legal && in_ram) begin
            o_DM_rd = mem[widx];
        end
`ifdef DMEM_MMIO_EN
        else if (i_DM_ren && legal && in_mmio) begin
            o_DM_rd = mmio_rd;
        end
`endif
    end

endmodule
